// File: rtl/array_2_ctrl.sv
// Request-side controller for the 512x4x19 tag/metadata SRAM: post-reset clear sweep,
// write-priority arbitration onto RW0, 1-cycle read response. Option: ARRAY_2_RDATA_HOLD_EN.
module array_2_ctrl #(
    parameter int unsigned SETS     = 512,
    parameter int unsigned WAYS     = 4,
    parameter int unsigned WAY_BITS = 19
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          r_req_valid,
    output logic                          r_req_ready,
    input  logic [$clog2(SETS)-1:0]       r_req_setIdx,
    output logic                          r_resp_valid,
    output logic [WAYS*WAY_BITS-1:0]      r_resp_data,
    input  logic                          w_req_valid,
    output logic                          w_req_ready,
    input  logic [$clog2(SETS)-1:0]       w_req_setIdx,
    input  logic [WAYS*WAY_BITS-1:0]      w_req_data,
    input  logic [WAYS-1:0]               w_req_waymask,
    output logic                          reset_done,
    output logic [$clog2(SETS)-1:0]       RW0_addr,
    output logic                          RW0_en,
    output logic                          RW0_wmode,
    output logic [WAYS*WAY_BITS-1:0]      RW0_wdata,
    output logic [WAYS-1:0]               RW0_wmask,
    input  logic [WAYS*WAY_BITS-1:0]      RW0_rdata
);

    localparam int unsigned AW = $clog2(SETS);
    localparam logic [AW-1:0] LastSet = AW'(SETS - 1);

    typedef enum logic {StClear, StRun} state_t;

    state_t          state_q;
    logic [AW-1:0]   cnt_q;
    logic            resp_valid_q;
    logic            reset_done_q;
    logic            read_fire;

    always_comb begin
        RW0_en      = 1'b0;
        RW0_wmode   = 1'b0;
        RW0_addr    = '0;
        RW0_wdata   = '0;
        RW0_wmask   = '0;
        w_req_ready = !reset && (state_q == StRun);
        r_req_ready = w_req_ready && !w_req_valid;
        read_fire   = r_req_valid && r_req_ready;
        // Port stays idle while reset is held, regardless of the state it is leaving.
        if (!reset) begin
            if (state_q == StClear) begin
                RW0_en    = 1'b1;
                RW0_wmode = 1'b1;
                RW0_addr  = cnt_q;
                RW0_wmask = '1;
            end else if (w_req_valid) begin
                RW0_en    = 1'b1;
                RW0_wmode = 1'b1;
                RW0_addr  = w_req_setIdx;
                RW0_wdata = w_req_data;
                RW0_wmask = w_req_waymask;
            end else if (read_fire) begin
                RW0_en    = 1'b1;
                RW0_addr  = r_req_setIdx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StClear;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            reset_done_q <= 1'b0;
        end else begin
            resp_valid_q <= read_fire;
            if (state_q == StClear) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == LastSet) begin
                    state_q      <= StRun;
                    reset_done_q <= 1'b1;
                end
            end
        end
    end

    assign r_resp_valid = resp_valid_q;
    assign reset_done   = reset_done_q;

`ifdef ARRAY_2_RDATA_HOLD_EN
    logic [WAYS*WAY_BITS-1:0] hold_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_q <= '0;
        end else if (resp_valid_q) begin
            hold_q <= RW0_rdata;
        end
    end

    assign r_resp_data = resp_valid_q ? RW0_rdata : hold_q;
`else
    assign r_resp_data = RW0_rdata;
`endif

endmodule
